// File: rtl/dram_port_arbiter.sv
// Single data-memory port shared by the core (cpu_*) and the image loader (ext_*).
// Define DRAM_ARB_RR_EN for round-robin; default is ext-priority with a MAX_BURST fairness cap.
module dram_port_arbiter #(
   parameter int unsigned ADDR_W    = 19,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned MAX_BURST = 16,
   parameter logic [1:0]  WR_CODE   = 2'b10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              ext_req,
   input  logic              ext_we,
   input  logic [ADDR_W-1:0] ext_addr,
   input  logic [DATA_W-1:0] ext_wdata,
   output logic              ext_gnt,
   output logic              ext_rvalid,
   output logic [DATA_W-1:0] ext_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [1:0]        mem_write,
   input  logic [DATA_W-1:0] mem_d_out
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] OWN_CPU = 2'd1;
   localparam logic [1:0] OWN_EXT = 2'd2;

   logic [1:0] state;
   logic       cpu_win;
   logic       ext_win;
   logic       rd_cpu_q;
   logic       rd_ext_q;

`ifdef DRAM_ARB_RR_EN
   // On contention the requester that did not own the port last time wins.
   always_comb begin
      cpu_win = 1'b0;
      ext_win = 1'b0;
      if (!rst) begin
         if (cpu_req && ext_req) begin
            if (state == OWN_CPU)
               ext_win = 1'b1;
            else
               cpu_win = 1'b1;
         end else begin
            cpu_win = cpu_req;
            ext_win = ext_req;
         end
      end
   end
`else
   localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

   logic [CNT_W-1:0] burst_cnt;
   logic             burst_full;

   assign burst_full = (state == OWN_EXT) && (burst_cnt == CNT_W'(MAX_BURST));

   always_comb begin
      cpu_win = 1'b0;
      ext_win = 1'b0;
      if (!rst) begin
         if (ext_req && !(cpu_req && burst_full))
            ext_win = 1'b1;
         else if (cpu_req)
            cpu_win = 1'b1;
      end
   end

   // Counts ext grants taken while the core is waiting.
   always_ff @(posedge clk) begin
      if (rst)
         burst_cnt <= '0;
      else if (!cpu_req || cpu_win)
         burst_cnt <= '0;
      else if (ext_win && (burst_cnt != CNT_W'(MAX_BURST)))
         burst_cnt <= burst_cnt + CNT_W'(1);
   end
`endif

   assign cpu_gnt   = cpu_win;
   assign ext_gnt   = ext_win;
   assign cpu_rdata = mem_d_out;
   assign ext_rdata = mem_d_out;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_write  <= 2'b00;
         rd_cpu_q   <= 1'b0;
         rd_ext_q   <= 1'b0;
         cpu_rvalid <= 1'b0;
         ext_rvalid <= 1'b0;
      end else begin
         if (cpu_win) begin
            state     <= OWN_CPU;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_write <= cpu_we ? WR_CODE : 2'b00;
         end else if (ext_win) begin
            state     <= OWN_EXT;
            mem_addr  <= ext_addr;
            mem_wdata <= ext_wdata;
            mem_write <= ext_we ? WR_CODE : 2'b00;
         end else begin
            state     <= IDLE;
            mem_write <= 2'b00;
         end
         // Read tag travels alongside the memory's own register stage.
         rd_cpu_q   <= cpu_win && !cpu_we;
         rd_ext_q   <= ext_win && !ext_we;
         cpu_rvalid <= rd_cpu_q;
         ext_rvalid <= rd_ext_q;
      end
   end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Self-checking bench for dram_port_arbiter with a behavioural memory and a rule-level reference model.
// Honours DRAM_ARB_RR_EN to select the expected arbitration policy.
module tb_dram_port_arbiter;

   localparam int unsigned AW = 19;
   localparam int unsigned DW = 8;
   localparam int unsigned MB = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          ext_req, ext_we, ext_gnt, ext_rvalid;
   logic [AW-1:0] ext_addr;
   logic [DW-1:0] ext_wdata, ext_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [1:0]    mem_write;
   logic [DW-1:0] mem_d_out;

   dram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB), .WR_CODE(2'b10)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(ext_gnt), .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_d_out(mem_d_out)
   );

   always #5 clk = ~clk;

   // Registered single-port memory seen by the DUT.
   logic [DW-1:0] ram [0:(1<<AW)-1];
   always @(posedge clk) begin
      if (mem_write == 2'b10) ram[mem_addr] <= mem_wdata;
      mem_d_out <= ram[mem_addr];
   end

   // Reference model state.
   typedef struct { int due; bit ext; logic [DW-1:0] data; } rd_t;
   rd_t           pend[$];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [1:0]    em_w;
   logic [AW-1:0] em_a;
   logic [DW-1:0] em_d;
   int            last_owner;   // 0 none, 1 cpu, 2 ext
   int            streak;       // ext grants taken while cpu waits
   int            cyc;

   int checks = 0, passes = 0;
   logic          last_wc, last_we;
   int            n_cpu_g, n_ext_g, n_cpu_rv, n_ext_rv, n_cpu_seen;
   logic [DW-1:0] obs_cpu_data;
   logic          obs_cpu_rv;
   logic [DW-1:0] got_ext[$];
   int            got_cyc[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
   endtask

   function automatic void model_win(output logic wc, output logic wx);
      wc = 1'b0;
      wx = 1'b0;
      if (rst) return;
`ifdef DRAM_ARB_RR_EN
      if (cpu_req && ext_req) begin
         if (last_owner == 1) wx = 1'b1; else wc = 1'b1;
      end else begin
         wc = cpu_req;
         wx = ext_req;
      end
`else
      if (cpu_req && ext_req && last_owner == 2 && streak == MB) wc = 1'b1;
      else if (ext_req) wx = 1'b1;
      else if (cpu_req) wc = 1'b1;
`endif
   endfunction

   // One clock: check at negedge, advance the model across the posedge.
   task automatic cycle();
      logic          wc, wx, rv_c, rv_e;
      logic [DW-1:0] rd_exp;
      @(negedge clk);
      model_win(wc, wx);
      chk("cpu_gnt", cpu_gnt, wc);
      chk("ext_gnt", ext_gnt, wx);
      chk("one_gnt", cpu_gnt & ext_gnt, 0);
      rv_c = 1'b0; rv_e = 1'b0; rd_exp = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         if (pend[0].ext) rv_e = 1'b1; else rv_c = 1'b1;
         rd_exp = pend[0].data;
         void'(pend.pop_front());
      end
      chk("cpu_rvalid", cpu_rvalid, rv_c);
      chk("ext_rvalid", ext_rvalid, rv_e);
      if (rv_c) chk("cpu_rdata", cpu_rdata, rd_exp);
      if (rv_e) chk("ext_rdata", ext_rdata, rd_exp);
      chk("mem_write", mem_write, em_w);
      chk("mem_addr", mem_addr, em_a);
      chk("mem_wdata", mem_wdata, em_d);
      obs_cpu_rv = cpu_rvalid;
      obs_cpu_data = cpu_rdata;
      if (cpu_gnt) n_cpu_g++;
      if (ext_gnt) n_ext_g++;
      if (cpu_rvalid) n_cpu_rv++;
      if (ext_rvalid) begin
         n_ext_rv++;
         got_ext.push_back(ext_rdata);
         got_cyc.push_back(cyc);
      end
      if (mem_write == 2'b10 && mem_addr == 19'h7FFFF) n_cpu_seen++;
      last_wc = wc;
      last_we = wx;
      if (rst) begin
         em_w = 2'b00; em_a = '0; em_d = '0;
         pend.delete();
         last_owner = 0;
         streak = 0;
      end else begin
         if (wc || wx) begin
            em_a = wc ? cpu_addr : ext_addr;
            em_d = wc ? cpu_wdata : ext_wdata;
            if (wc ? cpu_we : ext_we) begin
               em_w = 2'b10;
               ref_mem[em_a] = em_d;
            end else begin
               em_w = 2'b00;
               pend.push_back('{due: cyc + 2, ext: wx, data: ref_mem[em_a]});
            end
         end else begin
            em_w = 2'b00;
         end
         last_owner = wc ? 1 : (wx ? 2 : 0);
         if (!cpu_req || wc) streak = 0;
         else if (wx && streak < MB) streak++;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_reqs();
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
   endtask

   task automatic clr_counts();
      n_cpu_g = 0; n_ext_g = 0; n_cpu_rv = 0; n_ext_rv = 0; n_cpu_seen = 0;
      got_ext.delete();
      got_cyc.delete();
   endtask

   initial begin
      for (int i = 0; i < (1 << AW); i++) begin
         ram[i] = '0;
         ref_mem[i] = '0;
      end
      em_w = 2'b00; em_a = '0; em_d = '0;
      last_owner = 0; streak = 0; cyc = 0;
      obs_cpu_rv = 1'b0; obs_cpu_data = '0;
      clr_counts();
      idle_reqs();
      rst = 1'b1;
      // Outputs are unknown until the first reset edge.
      repeat (2) @(posedge clk);
      #1;
      cycle();          // reset state, request-free
      cpu_req = 1'b1; ext_req = 1'b1;
      cycle();          // grants suppressed while rst is high
      rst = 1'b0;
      idle_reqs();
      cycle();

      // cpu write 0x00005 <= 0xA5, then read back.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00005; cpu_wdata = 8'hA5;
      cycle();
      cpu_we = 1'b0; cpu_wdata = 8'h00;
      cycle();
      idle_reqs();
      cycle();
      cycle();
      chk("raw_rvalid", obs_cpu_rv, 1);
      chk("raw_rdata", obs_cpu_data, 8'hA5);

      // ext burst reads of preloaded bytes.
      for (int i = 0; i < 4; i++) begin
         ram[i] = 8'(8'h11 * (i + 1));
         ref_mem[i] = 8'(8'h11 * (i + 1));
      end
      clr_counts();
      for (int i = 0; i < 4; i++) begin
         ext_req = 1'b1; ext_we = 1'b0; ext_addr = 19'(i);
         cycle();
      end
      idle_reqs();
      repeat (3) cycle();
      chk("ext_burst_cnt", got_ext.size(), 4);
      for (int i = 0; i < got_ext.size() && i < 4; i++) begin
         chk("ext_burst_data", got_ext[i], 8'(8'h11 * (i + 1)));
         if (i > 0) chk("ext_burst_b2b", got_cyc[i] - got_cyc[i-1], 1);
      end
      chk("ext_burst_cpu_rv", n_cpu_rv, 0);

      // Both held 40 cycles starting from an idle port.
      cycle();
      clr_counts();
      cpu_req = 1'b1; cpu_addr = 19'h00010;
      ext_req = 1'b1; ext_addr = 19'h00020;
      repeat (40) cycle();
      idle_reqs();
`ifdef DRAM_ARB_RR_EN
      chk("held_cpu_gnts", n_cpu_g, 20);
      chk("held_ext_gnts", n_ext_g, 20);
`else
      chk("held_cpu_gnts", n_cpu_g, 2);
      chk("held_ext_gnts", n_ext_g, 38);
`endif
      repeat (3) cycle();

`ifndef DRAM_ARB_RR_EN
      // cpu withdraws its request while ext owns the port.
      ext_req = 1'b1; ext_we = 1'b1; ext_addr = 19'h00100; ext_wdata = 8'h3C;
      cycle();
      clr_counts();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h7FFFF; cpu_wdata = 8'h5A;
      repeat (3) cycle();
      cpu_req = 1'b0;
      repeat (3) cycle();
      idle_reqs();
      repeat (2) cycle();
      chk("drop_cpu_gnts", n_cpu_g, 0);
      chk("drop_cpu_cmd", n_cpu_seen, 0);
`endif

      // Reads in flight when reset hits mid-stream.
      cpu_req = 1'b1; cpu_addr = 19'h00001;
      ext_req = 1'b1; ext_addr = 19'h00002;
      repeat (3) cycle();
      rst = 1'b1;
      repeat (2) cycle();
      rst = 1'b0;
      idle_reqs();
      clr_counts();
      repeat (4) cycle();
      chk("rst_stale_rv", n_cpu_rv + n_ext_rv, 0);

      // Randomised traffic; commands held while waiting, occasionally withdrawn.
      for (int i = 0; i < 300; i++) begin
         if (!(cpu_req && !last_wc && ($urandom_range(4) != 0))) begin
            cpu_req = ($urandom_range(2) != 0);
            cpu_we = $urandom_range(1) == 1;
            cpu_addr = 19'($urandom_range(15));
            cpu_wdata = 8'($urandom);
         end
         if (!(ext_req && !last_we && ($urandom_range(4) != 0))) begin
            ext_req = ($urandom_range(2) != 0);
            ext_we = $urandom_range(1) == 1;
            ext_addr = 19'($urandom_range(15));
            ext_wdata = 8'($urandom);
         end
         cycle();
      end
      idle_reqs();
      repeat (3) cycle();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
